capture_trigger: RTL
====================

Name: capture_trigger

Overview:
- Upstream stage of filter_manager.
- Watches the raw 8-bit sample stream from the receiver ADC path and keeps a pre-trigger history in a ring buffer.
- Detects a rising threshold crossing with hysteresis, then emits one `trigger` pulse followed by exactly CAPTURE_LENGTH samples on `axiov`/`axiod`: PRE_TRIGGER history samples, then the trigger sample, then live samples.
- Output ports connect directly to filter_manager `trigger`/`axiiv`/`axiid`.

Parameters:
- SAMPLE_DATA_WIDTH, 8, sample width in bits.
- CAPTURE_LENGTH, 1000, total samples emitted per capture (includes pre-trigger history).
- PRE_TRIGGER, 100, history samples emitted before the trigger sample; must satisfy 0 ≤ PRE_TRIGGER < CAPTURE_LENGTH.
- HYSTERESIS, 4, amount the signal must fall below `threshold` before a new crossing is accepted.
- RING_DEPTH, 128, ring entries; power of two, ≥ PRE_TRIGGER+2.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, asynchronous active-low reset; all state clears while low.
- arm, input, 1, one-cycle pulse that starts a capture. Ignored unless IDLE.
- force_trigger, input, 1, software trigger. Honoured only in WAIT_TRIG.
- threshold, input, SAMPLE_DATA_WIDTH, unsigned trigger level. Sampled on `arm` and held for the whole capture.
- axiiv, input, 1, input sample valid (single-cycle, sparse: ~1 per 2000 clk).
- axiid, input, SAMPLE_DATA_WIDTH, input sample.
- trigger, output, 1, one-cycle pulse marking capture start.
- axiov, output, 1, output sample valid.
- axiod, output, SAMPLE_DATA_WIDTH, output sample.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset values: `trigger`=0, `axiov`=0, `axiod`=0, `busy`=0, state=IDLE. Ring pointers, occupancy, emitted-sample counter and `armed_low` all 0.
- Samples are unsigned. Low level = `threshold` − HYSTERESIS, saturating at 0.
- IDLE:
  - `axiiv` ignored.
  - `arm` latches `threshold`, clears ring and counters, and moves to PREFILL on the next cycle.
- PREFILL:
  - Each `axiiv` writes `axiid` to the ring.
  - When occupancy reaches PRE_TRIGGER, go to WAIT_TRIG (immediately if PRE_TRIGGER=0).
  - Crossings are ignored here.
- WAIT_TRIG:
  - Each `axiiv` writes the sample. If occupancy is already PRE_TRIGGER+1, the oldest entry is dropped in the same cycle, so history stays at PRE_TRIGGER plus the new sample.
  - A sample strictly below the low level sets `armed_low`.
  - A sample with `armed_low`=1 and sample ≥ latched threshold is the trigger sample. It is written to the ring, then:
    - `armed_low` clears;
    - `trigger`=1 on the following cycle;
    - state goes to EMIT.
  - If `force_trigger` and `axiiv` occur in the same cycle, that sample is the trigger sample.
  - If `force_trigger` occurs with no valid input, the trigger pulse fires next cycle with no trigger sample; the next arriving sample takes its place.
- EMIT:
  - `trigger` is held low after its pulse.
  - On each cycle after the trigger pulse where occupancy > 0, pop the oldest entry. It appears on `axiod` with `axiov`=1 on the next cycle, one sample per cycle.
  - Live `axiiv` samples keep being written. A write and a pop in the same cycle leave occupancy unchanged.
  - Latency:
    - Trigger sample accepted in cycle N.
    - `trigger` high in N+1.
    - History samples on `axiov` in cycles N+2 … N+1+PRE_TRIGGER.
    - Trigger sample in cycle N+2+PRE_TRIGGER.
    - Each later live sample appears 2 cycles after its `axiiv`.
  - Stop after CAPTURE_LENGTH emitted samples, then return to IDLE. Live samples beyond the count are discarded.
- The ring never overflows: drain rate is 1/cycle and input is sparse. An occupancy-full write in EMIT drops the sample; this is asserted in simulation.
- `arm` while busy has no effect.
- Reset asserted mid-capture aborts immediately with no partial pulses. After release, outputs stay quiet until the next `arm`.

Decomposition:
- Package `capture_pkg`:
  - state enum `capture_state_t` (IDLE, PREFILL, WAIT_TRIG, EMIT);
  - `localparam` widths for the counter (`$clog2(CAPTURE_LENGTH+1)`) and ring pointer (`$clog2(RING_DEPTH)`).
- Sub-module `sample_ring`:
  - parameterised circular buffer with write, pop, drop-oldest and clear;
  - occupancy output;
  - registered read data.

Test Plan:
- Ramp 0..255 step 1 (one sample per 2000 clk), threshold=128, PRE_TRIGGER=100 → `trigger` pulse 1 clk after sample 128. The 1000 emitted samples are 28..1027 mod 256; sample 128 is at output index 100.
- Signal starting at 200 (above threshold=128) with no dip below 124 → no trigger. Dip to 120 then 130 → trigger on the 130 sample.
- Signal oscillating 125↔130, threshold=128, HYSTERESIS=4 → never triggers (125 never goes below 124).
- `force_trigger` in WAIT_TRIG with flat input 50 → one `trigger` pulse, exactly 1000 `axiov` pulses all carrying 50, `busy` falls after the last one.
- Reset driven low during EMIT after 300 outputs → `axiov`, `trigger` and `busy` are 0 immediately. A fresh `arm` yields a clean full 1000-sample capture.
- `arm` pulsed during EMIT → ignored: output count is still 1000 and the latched threshold is unchanged.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and sizing helpers for the capture trigger front end.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        EMIT
    } capture_state_t;

    localparam int DEF_CAPTURE_LENGTH = 1000;
    localparam int DEF_RING_DEPTH     = 128;

    // Counter must hold CAPTURE_LENGTH itself, not just CAPTURE_LENGTH-1.
    function automatic int cnt_width(input int capture_length);
        return $clog2(capture_length + 1);
    endfunction

    function automatic int ptr_width(input int ring_depth);
        return $clog2(ring_depth);
    endfunction

endpackage

// File: rtl/capture_trigger_sample_ring.sv
// Power-of-two circular sample buffer with write, pop, drop-oldest and clear.
// Popped data is presented on a registered read port one cycle later.
module sample_ring
    import capture_pkg::*;
#(
    parameter int DEPTH = DEF_RING_DEPTH,
    parameter int WIDTH = 8,
    localparam int OCC_W = ptr_width(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    input  logic             drop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [OCC_W-1:0] occ_o
);

    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             empty, full, do_pop, do_drop, do_wr, do_adv;

    assign empty   = (occ_q == '0);
    assign full    = (occ_q == OCC_W'(DEPTH));
    assign do_pop  = pop_i && !empty && !clr_i;
    assign do_drop = drop_i && !pop_i && !empty && !clr_i;
    assign do_adv  = do_pop || do_drop;
    // A full ring still accepts a write when an entry leaves in the same cycle.
    assign do_wr   = wr_i && !clr_i && (!full || do_adv);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_adv) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_wr, do_adv})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (do_pop) rd_data_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = rd_data_q;
    assign occ_o     = occ_q;

endmodule

// File: rtl/capture_trigger.sv
// Threshold-crossing capture front end: keeps pre-trigger history in a ring and
// emits one trigger pulse followed by CAPTURE_LENGTH samples.
module capture_trigger
    import capture_pkg::*;
#(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int CAPTURE_LENGTH    = DEF_CAPTURE_LENGTH,
    parameter int PRE_TRIGGER       = 100,
    parameter int HYSTERESIS        = 4,
    parameter int RING_DEPTH        = DEF_RING_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         force_trigger,
    input  logic [SAMPLE_DATA_WIDTH-1:0] threshold,
    input  logic                         axiiv,
    input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
    output logic                         trigger,
    output logic                         axiov,
    output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
    output logic                         busy
);

    localparam int W     = SAMPLE_DATA_WIDTH;
    localparam int WE    = W + 1;
    localparam int CNT_W = cnt_width(CAPTURE_LENGTH);
    localparam int OCC_W = ptr_width(RING_DEPTH) + 1;

    localparam logic [OCC_W-1:0] PRE_OCC   = OCC_W'(PRE_TRIGGER);
    localparam logic [OCC_W-1:0] HIST_FULL = OCC_W'(PRE_TRIGGER + 1);
    localparam logic [OCC_W-1:0] RING_FULL = OCC_W'(RING_DEPTH);
    localparam logic [CNT_W-1:0] CAP_CNT   = CNT_W'(CAPTURE_LENGTH);
    localparam logic [WE-1:0]    HYST_EXT  = WE'(HYSTERESIS);

    capture_state_t   state_q, state_d;
    logic [W-1:0]     thr_q, thr_d;
    logic             armed_low_q, armed_low_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trigger_q, trigger_d;
    logic             axiov_q;

    logic             ring_clr, ring_wr, ring_pop, ring_drop;
    logic [W-1:0]     ring_rd_data;
    logic [OCC_W-1:0] ring_occ;
    logic [OCC_W-1:0] occ_after_wr;

    logic [WE-1:0]    thr_ext, low_level;
    logic             below_low, at_or_above_thr, fire, done;

    // Low level saturates at zero rather than wrapping for small thresholds.
    assign thr_ext         = {1'b0, thr_q};
    assign low_level       = (thr_ext >= HYST_EXT) ? (thr_ext - HYST_EXT) : '0;
    assign below_low       = ({1'b0, axiid} < low_level);
    assign at_or_above_thr = (axiid >= thr_q);
    assign fire            = force_trigger || (axiiv && armed_low_q && at_or_above_thr);
    assign done            = (cnt_q == CAP_CNT);
    assign occ_after_wr    = ring_occ + OCC_W'(axiiv);

    always_comb begin
        state_d     = state_q;
        thr_d       = thr_q;
        armed_low_d = armed_low_q;
        cnt_d       = cnt_q;
        trigger_d   = 1'b0;
        ring_clr    = 1'b0;
        ring_wr     = 1'b0;
        ring_pop    = 1'b0;
        ring_drop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    thr_d       = threshold;
                    armed_low_d = 1'b0;
                    cnt_d       = '0;
                    ring_clr    = 1'b1;
                    state_d     = PREFILL;
                end
            end
            PREFILL: begin
                ring_wr = axiiv;
                if (occ_after_wr >= PRE_OCC) state_d = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                ring_wr = axiiv;
                // A sample-less force also trims to PRE_TRIGGER so the next
                // arriving sample lands exactly where the trigger sample would.
                ring_drop = (axiiv || fire) && (ring_occ == HIST_FULL);
                if (fire) begin
                    trigger_d   = 1'b1;
                    armed_low_d = 1'b0;
                    state_d     = EMIT;
                end else if (axiiv && below_low) begin
                    armed_low_d = 1'b1;
                end
            end
            EMIT: begin
                ring_wr  = axiiv && !done;
                ring_pop = !done && (ring_occ != '0);
                if (ring_pop) cnt_d = cnt_q + 1'b1;
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            thr_q       <= '0;
            armed_low_q <= 1'b0;
            cnt_q       <= '0;
            trigger_q   <= 1'b0;
            axiov_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            thr_q       <= thr_d;
            armed_low_q <= armed_low_d;
            cnt_q       <= cnt_d;
            trigger_q   <= trigger_d;
            axiov_q     <= ring_pop;
        end
    end

    sample_ring #(
        .DEPTH (RING_DEPTH),
        .WIDTH (W)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (ring_clr),
        .wr_i      (ring_wr),
        .wr_data_i (axiid),
        .pop_i     (ring_pop),
        .drop_i    (ring_drop),
        .rd_data_o (ring_rd_data),
        .occ_o     (ring_occ)
    );

    // Input is sparse and drain is one per cycle, so a full ring here is a bug upstream.
    assert property (@(posedge clk) disable iff (!rst)
        !(state_q == EMIT && ring_wr && ring_occ == RING_FULL && !ring_pop));

    assign trigger = trigger_q;
    assign axiov   = axiov_q;
    assign axiod   = ring_rd_data;
    assign busy    = (state_q != IDLE);

endmodule
